// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stage stall/flush, redirect PC, interrupt detect and control registers.
// Optional HALT state is built only when CPU_CTRL_HALT_EN is defined.
module pipe_ctrl #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int IRQ_W  = 8,
  parameter int EXP_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              ld_hazard,
  input  logic [IRQ_W-1:0]  irq,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic              mem_en_,
  input  logic              mem_br_flag,
  input  logic [1:0]        mem_ctrl_op,
  input  logic [EXP_W-1:0]  mem_exp_code,
  input  logic [2:0]        mem_dst_addr,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [2:0]        creg_rd_addr,
  output logic [DATA_W-1:0] creg_rd_data,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              int_detect,
  output logic              exe_mode
);

  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_EXRT = 2'd2;

  logic [1:0]        status_r;
  logic [1:0]        pre_status_r;
  logic [ADDR_W-1:0] epc_r;
  logic [ADDR_W-1:0] exp_vector_r;
  logic [EXP_W:0]    cause_r;
  logic [IRQ_W-1:0]  int_mask_r;

  logic stall_s, hold_s, stall_eff_s, halted_s, irq_pend_s;
  logic act_s, exp_s, exrt_s, wrcr_s;

  assign irq_pend_s  = |(irq & ~int_mask_r);
  assign stall_s     = if_busy | mem_busy;
  // A halted core holds every stage until an unmasked request wakes it.
  assign hold_s      = halted_s & ~irq_pend_s;
  assign stall_eff_s = stall_s | hold_s;
  assign act_s       = ~reset & ~mem_en_ & ~stall_eff_s;
  assign exp_s       = act_s & (mem_exp_code != {EXP_W{1'b0}});
  assign exrt_s      = act_s & ~exp_s & (mem_ctrl_op == OP_EXRT);
  assign wrcr_s      = act_s & ~exp_s & (mem_ctrl_op == OP_WRCR);

  assign int_detect  = ~reset & status_r[1] & irq_pend_s & ~halted_s;
  assign exe_mode    = status_r[0];

`ifdef CPU_CTRL_HALT_EN
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  localparam logic [1:0] OP_HALT = 2'd3;
  state_t state_r, state_nxt_s;
  logic   halt_req_s;

  assign halt_req_s = act_s & ~exp_s & (mem_ctrl_op == OP_HALT);
  assign halted_s   = (state_r == HALT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= RUN;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; a HALT retiring on the wake cycle re-enters HALT
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN:     if (halt_req_s) state_nxt_s = HALT; else state_nxt_s = RUN;
      HALT:    if (irq_pend_s & ~halt_req_s) state_nxt_s = RUN; else state_nxt_s = HALT;
      default: state_nxt_s = RUN;
    endcase
  end
`else
  assign halted_s = 1'b0;
`endif

  // Stall, flush and redirect generation
  always_comb begin
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    new_pc    = {ADDR_W{1'b0}};
    if (reset) begin
      {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
    end else if (exp_s) begin
      {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
      new_pc = exp_vector_r;
    end else if (exrt_s) begin
      {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
      new_pc = epc_r;
    end else begin
      if_stall  = stall_eff_s | ld_hazard;
      id_stall  = stall_eff_s | ld_hazard;
      ex_stall  = stall_eff_s;
      mem_stall = stall_eff_s;
      // Bubble into EX only while the pipe is moving, else EX would lose its op.
      id_flush  = ld_hazard & ~stall_eff_s;
    end
  end

  // Control-register file updates
  always_ff @(posedge clk) begin
    if (reset) begin
      status_r     <= 2'b00;
      pre_status_r <= 2'b00;
      epc_r        <= {ADDR_W{1'b0}};
      exp_vector_r <= {ADDR_W{1'b0}};
      cause_r      <= {(EXP_W+1){1'b0}};
      int_mask_r   <= {IRQ_W{1'b1}};
    end else if (exp_s) begin
      epc_r        <= mem_pc;
      cause_r      <= {mem_br_flag, mem_exp_code};
      pre_status_r <= status_r;
      status_r     <= 2'b00;
    end else if (exrt_s) begin
      status_r     <= pre_status_r;
    end else if (wrcr_s) begin
      case (mem_dst_addr)
        3'd0:    status_r     <= mem_out[1:0];
        3'd1:    pre_status_r <= mem_out[1:0];
        3'd2:    epc_r        <= mem_out[ADDR_W+1:2];
        3'd3:    exp_vector_r <= mem_out[ADDR_W+1:2];
        3'd4:    cause_r      <= mem_out[EXP_W:0];
        3'd5:    int_mask_r   <= mem_out[IRQ_W-1:0];
        default: status_r     <= status_r;
      endcase
    end else begin
      status_r <= status_r;
    end
  end

  // Combinational register read, zero-extended
  always_comb begin
    creg_rd_data = {DATA_W{1'b0}};
    case (creg_rd_addr)
      3'd0:    creg_rd_data[1:0]        = status_r;
      3'd1:    creg_rd_data[1:0]        = pre_status_r;
      3'd2:    creg_rd_data[ADDR_W+1:2] = epc_r;
      3'd3:    creg_rd_data[ADDR_W+1:2] = exp_vector_r;
      3'd4:    creg_rd_data[EXP_W:0]    = cause_r;
      3'd5:    creg_rd_data[IRQ_W-1:0]  = int_mask_r;
      default: creg_rd_data             = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; HALT checks follow CPU_CTRL_HALT_EN.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        reset, if_busy, mem_busy, ld_hazard;
  logic [7:0]  irq;
  logic [29:0] mem_pc;
  logic        mem_en_, mem_br_flag;
  logic [1:0]  mem_ctrl_op;
  logic [2:0]  mem_exp_code, mem_dst_addr, creg_rd_addr;
  logic [31:0] mem_out, creg_rd_data;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc;
  logic        int_detect, exe_mode;
  logic [3:0]  stalls, flushes;
  int          n_checks = 0;
  int          n_fail = 0;

  assign stalls  = {if_stall, id_stall, ex_stall, mem_stall};
  assign flushes = {if_flush, id_flush, ex_flush, mem_flush};

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
    .ld_hazard(ld_hazard), .irq(irq), .mem_pc(mem_pc), .mem_en_(mem_en_),
    .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op), .mem_exp_code(mem_exp_code),
    .mem_dst_addr(mem_dst_addr), .mem_out(mem_out), .creg_rd_addr(creg_rd_addr),
    .creg_rd_data(creg_rd_data), .if_stall(if_stall), .id_stall(id_stall),
    .ex_stall(ex_stall), .mem_stall(mem_stall), .if_flush(if_flush),
    .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc), .int_detect(int_detect), .exe_mode(exe_mode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_mem();
    mem_en_ = 1'b1; mem_ctrl_op = 2'd0; mem_exp_code = 3'd0;
    mem_br_flag = 1'b0; mem_dst_addr = 3'd0; mem_out = 32'd0; mem_pc = 30'd0;
  endtask

  task automatic wrcr(input logic [2:0] idx, input logic [31:0] data);
    mem_en_ = 1'b0; mem_ctrl_op = 2'd1; mem_dst_addr = idx; mem_out = data;
    step();
    idle_mem();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (flushes !== 4'hF) begin n_fail++; $display("FAIL reset_flush: got %b want 1111", flushes); end
    n_checks++; if (stalls !== 4'h0) begin n_fail++; $display("FAIL reset_stall: got %b want 0000", stalls); end
    n_checks++; if (new_pc !== 30'd0) begin n_fail++; $display("FAIL reset_new_pc: got %h want 0", new_pc); end
    reset = 1'b0;
    creg_rd_addr = 3'd5;
    #1;
    n_checks++; if (flushes !== 4'h0) begin n_fail++; $display("FAIL post_reset_flush: got %b want 0000", flushes); end
    n_checks++; if (creg_rd_data !== 32'h0000_00FF) begin n_fail++; $display("FAIL reset_int_mask: got %h want 000000ff", creg_rd_data); end
    n_checks++; if (int_detect !== 1'b0) begin n_fail++; $display("FAIL reset_int_detect: got %b want 0", int_detect); end
    creg_rd_addr = 3'd0;
    #1;
    n_checks++; if (creg_rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h want 0", creg_rd_data); end
    step();
  endtask

  task automatic test_ld_hazard();
    ld_hazard = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (stalls !== 4'b1100) begin n_fail++; $display("FAIL ld_stall: got %b want 1100", stalls); end
      n_checks++; if (flushes !== 4'b0100) begin n_fail++; $display("FAIL ld_flush: got %b want 0100", flushes); end
      step();
    end
    ld_hazard = 1'b0;
    #1;
    n_checks++; if (stalls !== 4'b0000) begin n_fail++; $display("FAIL ld_release_stall: got %b want 0000", stalls); end
    n_checks++; if (flushes !== 4'b0000) begin n_fail++; $display("FAIL ld_release_flush: got %b want 0000", flushes); end
  endtask

  task automatic test_exception();
    wrcr(3'd3, 32'h100);
    wrcr(3'd0, 32'h2);
    creg_rd_addr = 3'd3; #1;
    n_checks++; if (creg_rd_data !== 32'h100) begin n_fail++; $display("FAIL wrcr_vector: got %h want 100", creg_rd_data); end
    // exception on an instruction that also carries WRCR to int_mask: exception wins
    mem_en_ = 1'b0; mem_exp_code = 3'd2; mem_pc = 30'h1; mem_br_flag = 1'b1;
    mem_ctrl_op = 2'd1; mem_dst_addr = 3'd5; mem_out = 32'h0;
    #1;
    n_checks++; if (flushes !== 4'hF) begin n_fail++; $display("FAIL exc_flush: got %b want 1111", flushes); end
    n_checks++; if (new_pc !== 30'h40) begin n_fail++; $display("FAIL exc_new_pc: got %h want 40", new_pc); end
    step();
    idle_mem();
    creg_rd_addr = 3'd2; #1;
    n_checks++; if (creg_rd_data !== 32'h4) begin n_fail++; $display("FAIL exc_epc: got %h want 4", creg_rd_data); end
    creg_rd_addr = 3'd4; #1;
    n_checks++; if (creg_rd_data !== 32'hA) begin n_fail++; $display("FAIL exc_cause: got %h want a", creg_rd_data); end
    creg_rd_addr = 3'd0; #1;
    n_checks++; if (creg_rd_data !== 32'h0) begin n_fail++; $display("FAIL exc_status: got %h want 0", creg_rd_data); end
    creg_rd_addr = 3'd1; #1;
    n_checks++; if (creg_rd_data !== 32'h2) begin n_fail++; $display("FAIL exc_pre_status: got %h want 2", creg_rd_data); end
    creg_rd_addr = 3'd5; #1;
    n_checks++; if (creg_rd_data !== 32'hFF) begin n_fail++; $display("FAIL exc_priority_mask: got %h want ff", creg_rd_data); end
    creg_rd_addr = 3'd6; #1;
    n_checks++; if (creg_rd_data !== 32'h0) begin n_fail++; $display("FAIL creg6_read: got %h want 0", creg_rd_data); end
  endtask

  task automatic test_exrt();
    mem_en_ = 1'b0; mem_ctrl_op = 2'd2;
    #1;
    n_checks++; if (flushes !== 4'hF) begin n_fail++; $display("FAIL exrt_flush: got %b want 1111", flushes); end
    n_checks++; if (new_pc !== 30'h1) begin n_fail++; $display("FAIL exrt_new_pc: got %h want 1", new_pc); end
    step();
    idle_mem();
    creg_rd_addr = 3'd0; #1;
    n_checks++; if (creg_rd_data !== 32'h2) begin n_fail++; $display("FAIL exrt_status: got %h want 2", creg_rd_data); end
  endtask

  task automatic test_stall_hold();
    mem_busy = 1'b1;
    mem_en_ = 1'b0; mem_exp_code = 3'd3; mem_pc = 30'h10; mem_br_flag = 1'b0;
    creg_rd_addr = 3'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (flushes !== 4'h0) begin n_fail++; $display("FAIL busy_flush: got %b want 0000", flushes); end
      n_checks++; if (stalls !== 4'hF) begin n_fail++; $display("FAIL busy_stall: got %b want 1111", stalls); end
      step();
      n_checks++; if (creg_rd_data !== 32'h4) begin n_fail++; $display("FAIL busy_epc_held: got %h want 4", creg_rd_data); end
    end
    mem_busy = 1'b0;
    #1;
    n_checks++; if (flushes !== 4'hF) begin n_fail++; $display("FAIL busy_release_flush: got %b want 1111", flushes); end
    step();
    idle_mem();
    #1;
    n_checks++; if (creg_rd_data !== 32'h40) begin n_fail++; $display("FAIL busy_epc: got %h want 40", creg_rd_data); end
    creg_rd_addr = 3'd4; #1;
    n_checks++; if (creg_rd_data !== 32'h3) begin n_fail++; $display("FAIL busy_cause: got %h want 3", creg_rd_data); end
  endtask

  task automatic test_interrupt();
    irq = 8'h01;
    wrcr(3'd5, 32'hFE);
    #1;
    n_checks++; if (int_detect !== 1'b0) begin n_fail++; $display("FAIL int_ie_off: got %b want 0", int_detect); end
    wrcr(3'd0, 32'h2);
    #1;
    n_checks++; if (int_detect !== 1'b1) begin n_fail++; $display("FAIL int_detect_on: got %b want 1", int_detect); end
    irq = 8'h02; #1;
    n_checks++; if (int_detect !== 1'b0) begin n_fail++; $display("FAIL int_masked_line: got %b want 0", int_detect); end
    irq = 8'h01;
    wrcr(3'd5, 32'hFF);
    #1;
    n_checks++; if (int_detect !== 1'b0) begin n_fail++; $display("FAIL int_detect_masked: got %b want 0", int_detect); end
    irq = 8'h00;
  endtask

  task automatic test_halt();
    wrcr(3'd0, 32'h0);
    wrcr(3'd5, 32'hFE);
    mem_en_ = 1'b0; mem_ctrl_op = 2'd3;
    step();
    idle_mem();
    #1;
`ifdef CPU_CTRL_HALT_EN
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (stalls !== 4'hF) begin n_fail++; $display("FAIL halt_stall: got %b want 1111", stalls); end
      n_checks++; if (flushes !== 4'h0) begin n_fail++; $display("FAIL halt_flush: got %b want 0000", flushes); end
      step();
    end
    irq = 8'h01; #1;
    n_checks++; if (stalls !== 4'h0) begin n_fail++; $display("FAIL halt_wake_stall: got %b want 0000", stalls); end
    step();
    irq = 8'h00; #1;
    n_checks++; if (stalls !== 4'h0) begin n_fail++; $display("FAIL halt_run_stall: got %b want 0000", stalls); end
`else
    n_checks++; if (stalls !== 4'h0) begin n_fail++; $display("FAIL halt_nop_stall: got %b want 0000", stalls); end
    n_checks++; if (flushes !== 4'h0) begin n_fail++; $display("FAIL halt_nop_flush: got %b want 0000", flushes); end
`endif
  endtask

  initial begin
    reset = 1'b1; if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0;
    irq = 8'h00; creg_rd_addr = 3'd0;
    idle_mem();
    test_reset();
    test_ld_hazard();
    test_exception();
    test_exrt();
    test_stall_hold();
    test_interrupt();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage core (IF/ID/EX/MEM/WB). Generates per-stage stall and flush and the redirect PC, drives int_detect into ex_reg, and owns the control-register file (status, EPC, cause, exception vector, interrupt mask). Acts on MEM-stage outputs of ex_reg/mem_reg: exceptions, EXRT, WRCR and HALT. Stall, flush and redirect outputs are combinational; state and control registers are flops.

Parameters:
ADDR_W, 30, word-address width (pc, epc, vector)
DATA_W, 32, data width (creg write/read data)
IRQ_W, 8, number of interrupt request lines
EXP_W, 3, exception-code width; code 0 = no exception, code 1 = external interrupt

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_busy  in  1  IF bus wait
mem_busy  in  1  MEM bus wait
ld_hazard  in  1  load-use hazard detected in ID
irq  in  IRQ_W  level interrupt requests
mem_pc  in  ADDR_W  PC of the MEM-stage instruction
mem_en_  in  1  MEM-stage instruction valid, active-low
mem_br_flag  in  1  MEM-stage instruction sits in a delay slot
mem_ctrl_op  in  2  0=NOP, 1=WRCR, 2=EXRT, 3=HALT
mem_exp_code  in  EXP_W  MEM-stage exception code
mem_dst_addr  in  3  creg index for WRCR
mem_out  in  DATA_W  WRCR write data
creg_rd_addr  in  3  creg read index (from ID)
creg_rd_data  out  DATA_W  creg read data, combinational
if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage stalls
if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage flushes
new_pc  out  ADDR_W  redirect target, valid when if_flush=1
int_detect  out  1  unmasked interrupt pending, to ex_reg
exe_mode  out  1  0=kernel, 1=user

Behaviour:
- Clock/reset: one clock clk; reset is synchronous and active-high.
- Reset: state=RUN; status={ie=0, exe_mode=0}; pre_status=0; epc=0; exp_vector=0; cause=0; int_mask=all 1s (all interrupts masked). While reset=1: all flushes=1, all stalls=0, new_pc=0, int_detect=0.
- Control registers (index: content):
  - 0: status {bit1 ie, bit0 exe_mode}
  - 1: pre_status
  - 2: epc
  - 3: exp_vector
  - 4: cause {bit3 dly, bits2:0 code}
  - 5: int_mask
  - Indices 6 and 7 read 0; writes to them are ignored.
  - epc and exp_vector are read/written as {addr, 2'b00}.
- Read port: creg_rd_data is combinational from current register contents. There is no bypass of a same-cycle WRCR; ID handles that hazard.
- Base stall: stall = if_busy | mem_busy. All four stall outputs = stall.
- Load-use hazard: ld_hazard additionally raises if_stall and id_stall, and sets id_flush=1 to inject a bubble into EX.
- Event qualifier: act = ~mem_en_ & ~stall. No MEM event is taken while stall=1; the event is held and taken when stall drops.
- Exception (act & mem_exp_code != 0), within the same cycle:
  - all flushes=1; new_pc=exp_vector.
  - Next edge: epc<=mem_pc; cause<={mem_br_flag, mem_exp_code}; pre_status<=status; status<={ie=0, exe_mode=0}.
  - Exception has priority over any ctrl_op on the same instruction.
- EXRT (act, no exception, op=2): all flushes=1; new_pc=epc; status<=pre_status at the next edge.
- WRCR (act, no exception, op=1): write creg[mem_dst_addr]<=mem_out at the next edge. No flush.
- Interrupt detect: int_detect = ie & |(irq & ~int_mask) & state==RUN. Combinational; ex_reg converts it to code 1, which returns here through MEM.
- State machine:
  - RUN -> HALT on act & op=3 & no exception.
  - In HALT: all stalls=1, no flush.
  - HALT -> RUN when |(irq & ~int_mask)=1, independent of ie. On that cycle all stalls=0.
  - Reset in HALT returns to RUN.
- Simultaneous events: reset > exception > EXRT/WRCR/HALT > ld_hazard. ld_hazard is ignored in a cycle that flushes all stages.

Optional Feature:
CPU_CTRL_HALT_EN
- Defined: HALT state and op=3 behave as above.
- Undefined: op=3 is treated as NOP, the HALT state is not synthesised, and the state flop is removed.

Test Plan:
- Reset, then reset=0: all flushes fall to 0; creg_rd_addr=5 reads 0x000000FF (IRQ_W=8); int_detect=0.
- ld_hazard=1 with if_busy=0 and mem_busy=0: if_stall=1, id_stall=1, id_flush=1, ex_stall=0, mem_stall=0 for exactly the cycles ld_hazard=1.
- WRCR idx 3 with data 0x100, then MEM exception code 2 at mem_pc=0x01 with mem_br_flag=1: all flushes=1 and new_pc=0x40 in that cycle; next cycle epc reads 0x4, cause reads 0xA, ie=0.
- Exception arriving with mem_busy=1 for 3 cycles: no flush and no creg update during those 3 cycles; flush and capture occur on the 4th cycle.
- Set ie=1, int_mask=0xFE, drive irq=0x01: int_detect=1 in the same cycle; set int_mask=0xFF: int_detect=0.
- HALT (macro defined): all stalls=1 until unmasked irq=0x01, then RUN the next cycle. Macro undefined: op=3 gives no stall.
